sram_param: RTL and testbench



---
 rtl/sram_pkg.sv | 10 +
 rtl/sram_array.sv | 27 ++
 rtl/sram_param.sv | 125 ++++++++++++
 tb/tb_sram_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised single-port SRAM.
package sram_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // CLEAR zeroes the array after reset; IDLE serves requests.
  typedef enum logic {CLEAR, IDLE} state_e;

endpackage

// File: rtl/sram_array.sv
// Storage array: synchronous write port and registered synchronous read port.
module sram_array #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Callers only enable a port with an in-range address.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_param.sv
// Parametrised synchronous single-port SRAM with post-reset clear sequencer,
// registered read path with valid strobe, and out-of-range address detection.
module sram_param
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  inp,
  output logic [WIDTH-1:0]  outp,
  output logic              outp_valid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  // zero_q masks the array read register: set by reset and out-of-range reads.
  logic              zero_q, zero_d;

  logic              in_range;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [WIDTH-1:0]  arr_wdata, arr_rdata;

  assign in_range = ({1'b0, addr} < DepthExt);

  // State, clear counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Next state: walk every word once, then serve requests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: ;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs: array port control and next values of the output registers.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_waddr = addr;
    arr_wdata = inp;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    zero_d    = zero_q;
    unique case (state_q)
      CLEAR: begin
        // No words are touched while reset is held.
        arr_we    = !rst;
        arr_waddr = cnt_q;
        arr_wdata = '0;
      end
      IDLE: begin
        if (sel && !rst) begin
          if (op == OP_WRITE) begin
            arr_we = in_range;
            err_d  = !in_range;
          end else begin
            arr_re  = in_range;
            valid_d = 1'b1;
            err_d   = !in_range;
            zero_d  = !in_range;
          end
        end
      end
      default: ;
    endcase
  end

  sram_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .waddr_i(arr_waddr),
    .wdata_i(arr_wdata),
    .re_i   (arr_re),
    .raddr_i(addr),
    .rdata_o(arr_rdata)
  );

  assign outp       = zero_q ? '0 : arr_rdata;
  assign outp_valid = valid_q;
  assign err        = err_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_sram_param.sv
// Scoreboard bench for sram_param: an 8x8 instance and a 6x12 instance
// (non-power-of-two depth), each checked against a behavioural model.
module tb_sram_param;

  typedef struct {
    int          due;
    bit          valid;
    bit          err;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pend[2];

  logic        rst_a[2];
  logic        sel_a[2];
  logic        op_a[2];
  logic [2:0]  addr_a[2];
  logic [15:0] inp_a[2];

  function automatic void chk(string name, int k, logic [15:0] act, logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h want %h", name, k, act, req);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 8 : 12;
    localparam int unsigned D = (g == 0) ? 8 : 6;
    localparam logic [15:0] Mask = 16'((32'd1 << W) - 1);

    logic [W-1:0] outp;
    logic         outp_valid, busy, err;

    sram_param #(
      .WIDTH(W),
      .DEPTH(D)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_a[g]),
      .sel       (sel_a[g]),
      .op        (op_a[g]),
      .addr      (addr_a[g]),
      .inp       (inp_a[g][W-1:0]),
      .outp      (outp),
      .outp_valid(outp_valid),
      .busy      (busy),
      .err       (err)
    );

    // Reference model: contents, remaining clear cycles, last read value.
    logic [15:0] mem[D];
    logic [15:0] exp_out = '0;
    exp_t        q[$];
    exp_t        e;
    int          cyc     = 0;
    int          clr_rem = 0;
    bit          armed   = 0;

    always @(posedge clk) begin
      if (rst_a[g]) begin
        armed   = 1;
        clr_rem = D;
        exp_out = '0;
        foreach (mem[i]) mem[i] = '0;
      end else if (clr_rem > 0) begin
        clr_rem--;
      end else if (armed && sel_a[g]) begin
        if (int'(addr_a[g]) >= int'(D)) begin
          q.push_back('{cyc + 1, !op_a[g], 1'b1, 16'h0});
          if (!op_a[g]) exp_out = '0;
        end else if (op_a[g]) begin
          mem[int'(addr_a[g])] = inp_a[g] & Mask;
        end else begin
          q.push_back('{cyc + 1, 1'b1, 1'b0, mem[int'(addr_a[g])]});
          exp_out = mem[int'(addr_a[g])];
        end
      end
      cyc++;
      pend[g] = q.size();
    end

    always @(negedge clk) begin
      if (armed) begin
        chk("busy", g, 16'(busy), 16'(clr_rem > 0));
        chk("outp_hold", g, 16'(outp), exp_out);
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("outp_valid", g, 16'(outp_valid), 16'(e.valid));
          chk("err", g, 16'(err), 16'(e.err));
          if (e.valid) chk("rdata", g, 16'(outp), e.data);
        end else if (outp_valid || err) begin
          n_tests++;
          n_fail++;
          $display("FAIL stray_pulse dut%0d: got valid=%0b err=%0b want 0 0",
                   g, outp_valid, err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(int k, bit o, int a, int d);
    sel_a[k]  = 1'b1;
    op_a[k]   = o;
    addr_a[k] = 3'(a);
    inp_a[k]  = 16'(d);
    tick();
    sel_a[k] = 1'b0;
  endtask

  task automatic idle(int k, int n);
    sel_a[k] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_rst(int k, int n);
    rst_a[k] = 1'b1;
    repeat (n) tick();
    rst_a[k] = 1'b0;
  endtask

  // Requests during the clear window must be ignored.
  task automatic busy_noise(int k, int n);
    for (int i = 0; i < n; i++) req(k, 1'($urandom_range(1, 0)), $urandom_range(7, 0), $urandom);
  endtask

  task automatic read_all(int k, int d);
    for (int i = 0; i < d; i++) req(k, 1'b0, i, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_a[k]  = 1'b1;
      sel_a[k]  = 1'b0;
      op_a[k]   = 1'b0;
      addr_a[k] = '0;
      inp_a[k]  = '0;
    end
    tick();
    tick();
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;

    // 8x8: clear, basic write/read, back-to-back, random, reset mid-clear.
    busy_noise(0, 8);
    read_all(0, 8);
    req(0, 1'b1, 3, 'hA5);
    req(0, 1'b0, 3, 0);
    req(0, 1'b0, 2, 0);
    req(0, 1'b0, 4, 0);
    idle(0, 2);
    for (int i = 0; i < 8; i++) req(0, 1'b1, i, 'h10 + i);
    read_all(0, 8);
    idle(0, 1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) idle(0, 1);
      else req(0, 1'($urandom_range(1, 0)), $urandom_range(7, 0), $urandom);
    end
    for (int i = 0; i < 8; i++) req(0, 1'b1, i, 'hFF);
    pulse_rst(0, 1);
    idle(0, 3);
    pulse_rst(0, 1);
    busy_noise(0, 8);
    read_all(0, 8);
    idle(0, 3);

    // 6x12: out-of-range detection, random including addresses 6 and 7.
    for (int i = 0; i < 6; i++) req(1, 1'b1, i, $urandom);
    read_all(1, 6);
    req(1, 1'b1, 6, 'hFFF);
    req(1, 1'b0, 7, 0);
    read_all(1, 6);
    req(1, 1'b0, 2, 0);
    req(1, 1'b0, 6, 0);
    idle(1, 2);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) idle(1, 1);
      else req(1, 1'($urandom_range(1, 0)), $urandom_range(7, 0), $urandom);
    end
    for (int i = 0; i < 6; i++) req(1, 1'b1, i, 'hFFF);
    pulse_rst(1, 1);
    idle(1, 3);
    pulse_rst(1, 1);
    busy_noise(1, 6);
    read_all(1, 6);
    idle(1, 3);

    for (int k = 0; k < 2; k++) chk("drain", k, 16'(pend[k]), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
